// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared types and constants for the byte-stream program loader.
//   - state_e : loader FSM states. The checksum states are always present so
//               the encoding is identical whether or not BOOT_CHECKSUM_EN is
//               defined.
//   - LEN_W   : width of the image length field.
//   - WORD_W  : width of a program memory word.
//   - csum_add: running checksum step (sum of words modulo 2**WORD_W).
// -----------------------------------------------------------------------------
package boot_pkg;

    localparam int LEN_W  = 16;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        LEN_LO  = 3'd0,
        LEN_HI  = 3'd1,
        DAT_LO  = 3'd2,
        DAT_HI  = 3'd3,
        CSUM_LO = 3'd4,
        CSUM_HI = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_e;

    // Checksum accumulation; the carry out of the top bit is intentionally dropped.
    function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] acc,
                                                   input logic [WORD_W-1:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/boot_loader_byte_pair_assembler.sv
// -----------------------------------------------------------------------------
// byte_pair_assembler
// Pairs consecutive accepted bytes into little-endian 16-bit words. The first
// byte of a pair is stored; when the second byte arrives the word is presented
// combinationally together with a one-cycle word_valid_o pulse, so the caller
// can register it on the very edge that accepts the high byte.
// Ports:
//   clk, reset    : clock and synchronous active-high reset (phase -> low byte)
//   byte_valid_i  : a byte belonging to a field is accepted this cycle
//   byte_i        : the accepted byte
//   word_valid_o  : high in the cycle the high byte is accepted
//   word_o        : {high byte, stored low byte}
// -----------------------------------------------------------------------------
module byte_pair_assembler
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic       hi_phase_q;
    logic       hi_phase_d;
    logic [7:0] lo_byte_q;
    logic [7:0] lo_byte_d;

    // Next-state logic: toggle the phase on every accepted byte, capture low bytes.
    always_comb begin
        hi_phase_d = hi_phase_q;
        lo_byte_d  = lo_byte_q;
        if (byte_valid_i) begin
            hi_phase_d = ~hi_phase_q;
            if (!hi_phase_q) begin
                lo_byte_d = byte_i;
            end else begin
                lo_byte_d = lo_byte_q;
            end
        end else begin
            hi_phase_d = hi_phase_q;
        end
    end

    // Phase and low-byte registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_phase_q <= 1'b0;
            lo_byte_q  <= 8'h00;
        end else begin
            hi_phase_q <= hi_phase_d;
            lo_byte_q  <= lo_byte_d;
        end
    end

    assign word_valid_o = byte_valid_i & hi_phase_q;
    assign word_o       = {byte_i, lo_byte_q};

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Byte-stream program loader. Receives a 16-bit little-endian length followed
// by that many little-endian 16-bit words, writes them to program memory
// starting at BASE_ADDR (wrapping modulo 2**ADDR_W) and then releases the core
// from reset. An oversize length parks the loader in an error state that keeps
// draining input bytes and keeps the core in reset.
// Optional feature (macro BOOT_CHECKSUM_EN): two extra bytes after the data
// carry the 16-bit sum of all data words; the core is released only on match.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   rx_data      : image byte
//   rx_valid     : rx_data valid
//   rx_ready     : loader can accept a byte (function of state only)
//   mem_we       : one-cycle program memory write strobe
//   mem_addr     : word write address (holds when mem_we=0)
//   mem_wdata    : word write data (holds when mem_we=0)
//   core_resetq  : active-low core reset, high only once loading is complete
//   done, error  : sticky completion / failure flags
// -----------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_resetq,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]       CAPACITY = 32'd1 << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
    localparam state_e AFTER_DATA = CSUM_LO;
`else
    localparam state_e AFTER_DATA = DONE;
`endif

    state_e              state_q;
    state_e              state_d;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_d;
    // One extra bit so that a full-capacity image length is representable.
    logic [ADDR_W:0]     idx_q;
    logic [ADDR_W:0]     idx_d;
    logic                rx_ready_q;
    logic                rx_ready_d;
    logic                mem_we_q;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic [WORD_W-1:0]   mem_wdata_d;
    logic                core_resetq_q;
    logic                core_resetq_d;
    logic                done_q;
    logic                done_d;
    logic                error_q;
    logic                error_d;
`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0]   csum_q;
    logic [WORD_W-1:0]   csum_d;
`endif

    logic                byte_acc_s;
    logic                byte_take_s;
    logic                word_valid_s;
    logic [WORD_W-1:0]   word_s;

    assign byte_acc_s  = rx_valid & rx_ready_q;
    // Bytes drained in ERROR never reach the assembler, so field pairing stays aligned.
    assign byte_take_s = byte_acc_s & (state_q != DONE) & (state_q != ERROR);

    byte_pair_assembler u_pair (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (byte_take_s),
        .byte_i       (rx_data),
        .word_valid_o (word_valid_s),
        .word_o       (word_s)
    );

    // FSM next state, memory write generation and registered output values.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            LEN_LO: begin
                if (byte_take_s) begin
                    state_d = LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            LEN_HI: begin
                if (word_valid_s) begin
                    len_d = word_s;
                    if (word_s == {LEN_W{1'b0}}) begin
                        state_d = AFTER_DATA;
                    end else if (32'(word_s) > CAPACITY) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DAT_LO;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DAT_LO: begin
                if (byte_take_s) begin
                    state_d = DAT_HI;
                end else begin
                    state_d = state_q;
                end
            end
            DAT_HI: begin
                if (word_valid_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_A + idx_q[ADDR_W-1:0];
                    mem_wdata_d = word_s;
                    idx_d       = idx_q + IDX_ONE;
`ifdef BOOT_CHECKSUM_EN
                    csum_d      = csum_add(csum_q, word_s);
`endif
                    if (32'(idx_d) == 32'(len_q)) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = DAT_LO;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM_LO: begin
                if (byte_take_s) begin
                    state_d = CSUM_HI;
                end else begin
                    state_d = state_q;
                end
            end
            CSUM_HI: begin
                if (word_valid_s) begin
                    if (word_s == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            DONE: begin
                state_d = DONE;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        // rx_ready follows the next state so no byte is taken once DONE is entered.
        rx_ready_d    = (state_d != DONE);
        // Flags follow the current state: done rises the cycle after the last write.
        done_d        = (state_q == DONE);
        core_resetq_d = (state_q == DONE);
        error_d       = (state_q == ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= LEN_LO;
            len_q         <= {LEN_W{1'b0}};
            idx_q         <= {(ADDR_W+1){1'b0}};
            rx_ready_q    <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= BASE_A;
            mem_wdata_q   <= {WORD_W{1'b0}};
            core_resetq_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q        <= {WORD_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            rx_ready_q    <= rx_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            core_resetq_q <= core_resetq_d;
            done_q        <= done_d;
            error_q       <= error_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign rx_ready    = rx_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign core_resetq = core_resetq_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Two loaders share one clock: dut0 (ADDR_W=13, BASE_ADDR=0) and dut1
// (ADDR_W=4, BASE_ADDR=14, small enough to hit capacity and address wrap).
// Expected writes, timing and final status come from a byte-stream model that
// parses the image directly from the protocol rules.
// -----------------------------------------------------------------------------
module tb_boot_loader;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];

    typedef struct {
        int len;
        bit exp_done;
        bit exp_err;
        int exp_writes;
    } vec_t;

    logic        clk = 1'b0;
    logic [1:0]  reset_s;
    logic [1:0]  rx_valid_s;
    logic [1:0]  rx_ready_s;
    logic [1:0]  mem_we_s;
    logic [1:0]  core_resetq_s;
    logic [1:0]  done_s;
    logic [1:0]  error_s;
    logic [7:0]  rx_data0;
    logic [7:0]  rx_data1;
    logic [12:0] mem_addr0;
    logic [3:0]  mem_addr1;
    logic [15:0] mem_wdata0;
    logic [15:0] mem_wdata1;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(13), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset(reset_s[0]), .rx_data(rx_data0), .rx_valid(rx_valid_s[0]),
        .rx_ready(rx_ready_s[0]), .mem_we(mem_we_s[0]), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .core_resetq(core_resetq_s[0]), .done(done_s[0]),
        .error(error_s[0])
    );

    boot_loader #(.ADDR_W(4), .BASE_ADDR(14)) dut1 (
        .clk(clk), .reset(reset_s[1]), .rx_data(rx_data1), .rx_valid(rx_valid_s[1]),
        .rx_ready(rx_ready_s[1]), .mem_we(mem_we_s[1]), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .core_resetq(core_resetq_s[1]), .done(done_s[1]),
        .error(error_s[1])
    );

    int cyc = 0;
    int n_chk = 0;
    int n_bad = 0;

    // Observed writes (only one DUT is active at a time) and first cycle of done.
    int w_addr[$];
    int w_data[$];
    int w_cyc[$];
    int done_cyc[2];
    // Edge number at which each byte of the current stream was accepted.
    int acc_cyc_q[$];

    // Model results.
    int exp_addr[$];
    int exp_data[$];
    int exp_hi[$];
    bit exp_done;
    bit exp_err;
    int exp_end;

    // Posedge counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Write and done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_s != 2'b00) begin
            w_addr.delete();
            w_data.delete();
            w_cyc.delete();
        end else begin
            if (mem_we_s[0] === 1'b1) begin
                w_addr.push_back(int'(mem_addr0));
                w_data.push_back(int'(mem_wdata0));
                w_cyc.push_back(cyc);
            end
            if (mem_we_s[1] === 1'b1) begin
                w_addr.push_back(int'(mem_addr1));
                w_data.push_back(int'(mem_wdata1));
                w_cyc.push_back(cyc);
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (reset_s[d] === 1'b1) done_cyc[d] <= -1;
            else if (done_s[d] === 1'b1 && done_cyc[d] < 0) done_cyc[d] <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_byte(input int d, input logic v, input logic [7:0] b);
        rx_valid_s[d] = v;
        if (d == 0) rx_data0 = b;
        else        rx_data1 = b;
    endtask

    // Two-cycle reset with a byte presented throughout; that byte must be dropped.
    task automatic do_reset(input int d);
        @(negedge clk);
        reset_s[d] = 1'b1;
        set_byte(d, 1'b1, 8'h05);
        repeat (2) @(negedge clk);
        reset_s[d] = 1'b0;
        set_byte(d, 1'b0, 8'h00);
    endtask

    task automatic send(input int d, input bq_t b, input int gap, output int n_acc);
        int t;
        n_acc = 0;
        acc_cyc_q.delete();
        @(negedge clk);
        for (int i = 0; i < b.size(); i++) begin
            set_byte(d, 1'b1, b[i]);
            t = 0;
            while (rx_ready_s[d] !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (rx_ready_s[d] === 1'b1) begin
                acc_cyc_q.push_back(cyc + 1);
                n_acc++;
            end else begin
                n_chk++;
                n_bad++;
                $display("FAIL send_timeout: byte %0d got ready=0 want ready=1", i);
            end
            @(negedge clk);
            if (gap > 0) begin
                set_byte(d, 1'b0, 8'($urandom_range(0, 255)));
                repeat (gap) @(negedge clk);
            end
        end
        set_byte(d, 1'b0, 8'h00);
    endtask

    // Parse a byte stream directly from the image format.
    task automatic run_model(input bq_t b, input int aw, input int base);
        int len, cap, sum, w, p, c;
        exp_addr.delete();
        exp_data.delete();
        exp_hi.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_end  = -1;
        if (b.size() < 2) return;
        len = int'(b[0]) + 256 * int'(b[1]);
        cap = 1 << aw;
        if (len > cap) begin
            exp_err = 1'b1;
            return;
        end
        sum = 0;
        for (int i = 0; i < len; i++) begin
            if (3 + 2 * i >= b.size()) return;
            w = int'(b[2 + 2 * i]) + 256 * int'(b[3 + 2 * i]);
            exp_addr.push_back((base + i) % cap);
            exp_data.push_back(w);
            exp_hi.push_back(3 + 2 * i);
            sum = (sum + w) % 65536;
        end
        p = 2 + 2 * len;
        if (CSUM) begin
            if (p + 1 >= b.size()) return;
            c = int'(b[p]) + 256 * int'(b[p + 1]);
            exp_end = p + 1;
            if (c == sum) exp_done = 1'b1;
            else          exp_err  = 1'b1;
        end else begin
            exp_done = 1'b1;
            exp_end  = (len == 0) ? 1 : p - 1;
        end
    endtask

    function automatic bq_t build(input int len, input int nwords);
        bq_t b;
        int  w;
        int  sum = 0;
        b.push_back(8'(len));
        b.push_back(8'(len >> 8));
        for (int i = 0; i < nwords; i++) begin
            w = int'($urandom_range(0, 65535));
            b.push_back(8'(w));
            b.push_back(8'(w >> 8));
            sum = sum + w;
        end
        if (CSUM && nwords == len) begin
            b.push_back(8'(sum));
            b.push_back(8'(sum >> 8));
        end
        return b;
    endfunction

    task automatic check_load(input int d, input bq_t b, input int aw, input int base,
                              input string nm);
        int n;
        run_model(b, aw, base);
        repeat (3) @(negedge clk);
        chk({nm, "_nwrites"}, w_addr.size(), exp_addr.size());
        n = (w_addr.size() < exp_addr.size()) ? w_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", nm, i), w_addr[i], exp_addr[i]);
            chk($sformatf("%s_data%0d", nm, i), w_data[i], exp_data[i]);
            if (exp_hi[i] < acc_cyc_q.size())
                chk($sformatf("%s_wcyc%0d", nm, i), w_cyc[i], acc_cyc_q[exp_hi[i]]);
        end
        chk({nm, "_done"}, done_s[d], exp_done);
        chk({nm, "_error"}, error_s[d], exp_err);
        chk({nm, "_core_resetq"}, core_resetq_s[d], exp_done);
        chk({nm, "_rx_ready"}, rx_ready_s[d], !exp_done);
        if (exp_done && exp_end >= 0 && exp_end < acc_cyc_q.size())
            chk({nm, "_done_cyc"}, done_cyc[d], acc_cyc_q[exp_end] + 1);
    endtask

    task automatic check_reset_vals(input int d, input string nm);
        chk({nm, "_rst_ready"}, rx_ready_s[d], 1'b1);
        chk({nm, "_rst_we"}, mem_we_s[d], 1'b0);
        chk({nm, "_rst_addr"}, (d == 0) ? 32'(mem_addr0) : 32'(mem_addr1), (d == 0) ? 0 : 14);
        chk({nm, "_rst_wdata"}, (d == 0) ? 32'(mem_wdata0) : 32'(mem_wdata1), 0);
        chk({nm, "_rst_core_resetq"}, core_resetq_s[d], 1'b0);
        chk({nm, "_rst_done"}, done_s[d], 1'b0);
        chk({nm, "_rst_error"}, error_s[d], 1'b0);
    endtask

    initial begin
        vec_t tbl[6];
        bq_t  b;
        bq_t  nom;
        int   nacc;
        int   len;
        int   gap;

        tbl[0] = '{0,      1'b1, 1'b0, 0};
        tbl[1] = '{1,      1'b1, 1'b0, 1};
        tbl[2] = '{16,     1'b1, 1'b0, 16};
        tbl[3] = '{17,     1'b0, 1'b1, 0};
        tbl[4] = '{65535,  1'b0, 1'b1, 0};
        tbl[5] = '{2,      1'b1, 1'b0, 2};

        reset_s    = 2'b00;
        rx_valid_s = 2'b00;
        rx_data0   = 8'h00;
        rx_data1   = 8'h00;

        do_reset(0);
        do_reset(1);
        check_reset_vals(0, "init0");
        check_reset_vals(1, "init1");

        // Nominal load, continuous bytes.
        nom = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
`ifdef BOOT_CHECKSUM_EN
        nom.push_back(8'h68);
        nom.push_back(8'h03);
`endif
        send(0, nom, 0, nacc);
        check_load(0, nom, 13, 0, "nominal");
        chk("nominal_w0", (w_data.size() > 0) ? w_data[0] : -1, 32'h1234);
        chk("nominal_w2", (w_data.size() > 2) ? w_data[2] : -1, 32'h9ABC);
        chk("nominal_a2", (w_addr.size() > 2) ? w_addr[2] : -1, 2);
`ifndef BOOT_CHECKSUM_EN
        chk("nominal_release", done_cyc[0], (w_cyc.size() > 2) ? w_cyc[2] + 1 : -1);
`endif

        // Same image with three idle cycles between bytes.
        do_reset(0);
        send(0, nom, 3, nacc);
        check_load(0, nom, 13, 0, "stall");

        // Zero length.
        do_reset(0);
        b = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        b.push_back(8'h00);
        b.push_back(8'h00);
`endif
        send(0, b, 0, nacc);
        check_load(0, b, 13, 0, "zero");

        // Oversize on the 16-word instance, followed by bytes that must drain.
        do_reset(1);
        b = '{8'h11, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(1, b, 1, nacc);
        check_load(1, b, 4, 14, "oversize");
        chk("oversize_drained", nacc, 6);
        chk("oversize_error", error_s[1], 1'b1);

        // Reset after the first of three words is written.
        do_reset(0);
        send(0, '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78}, 0, nacc);
        repeat (2) @(negedge clk);
        chk("midload_one_write", w_addr.size(), 1);
        do_reset(0);
        check_reset_vals(0, "midload");
        b = '{8'h01, 8'h00, 8'hEF, 8'hBE};
`ifdef BOOT_CHECKSUM_EN
        b.push_back(8'hEF);
        b.push_back(8'hBE);
`endif
        send(0, b, 0, nacc);
        check_load(0, b, 13, 0, "reload");
        chk("reload_data", (w_data.size() > 0) ? w_data[0] : -1, 32'hBEEF);

`ifdef BOOT_CHECKSUM_EN
        do_reset(0);
        b = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
        send(0, b, 0, nacc);
        check_load(0, b, 13, 0, "csum_ok");
        chk("csum_ok_done", done_s[0], 1'b1);
        do_reset(0);
        b = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00};
        send(0, b, 0, nacc);
        check_load(0, b, 13, 0, "csum_bad");
        chk("csum_bad_error", error_s[0], 1'b1);
        chk("csum_bad_core_resetq", core_resetq_s[0], 1'b0);
`endif

        // Length boundary table on the 16-word instance (base 14, wraps at 16).
        for (int i = 0; i < 6; i++) begin
            do_reset(1);
            b = build(tbl[i].len, (tbl[i].len > 16) ? 2 : tbl[i].len);
            send(1, b, 0, nacc);
            check_load(1, b, 4, 14, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_vdone", i), done_s[1], tbl[i].exp_done);
            chk($sformatf("tbl%0d_verr", i), error_s[1], tbl[i].exp_err);
            chk($sformatf("tbl%0d_vwrites", i), w_addr.size(), tbl[i].exp_writes);
            chk($sformatf("tbl%0d_accepted", i), nacc, b.size());
        end

        // Random images with random inter-byte gaps.
        for (int it = 0; it < 5; it++) begin
            do_reset(0);
            len = int'($urandom_range(1, 8));
            gap = int'($urandom_range(0, 2));
            b = build(len, len);
            send(0, b, gap, nacc);
            check_load(0, b, 13, 0, $sformatf("rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
